// File: rtl/phy_tx_pkg.sv
// Shared symbols, FSM encodings and lane-pair type for the 2-lane TX byte path.
// COM/SKP symbols and the SKP state exist only when SKP_INSERT_EN is defined.
package phy_tx_pkg;

  localparam int unsigned NUM_LANES = 2;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [7:0] PAD_SYM = 8'hF7;
`ifdef SKP_INSERT_EN
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef SKP_INSERT_EN
  localparam logic [1:0] ST_SKP  = 2'd2;
`endif

  // Index 0 is lane 0 (even bytes), index 1 is lane 1 (odd bytes).
  typedef logic [NUM_LANES-1:0][BYTE_W-1:0] lane_pair_t;

endpackage

// File: rtl/tx_skp_timer.sv
// SKP interval timer: free-running counter that raises a sticky request at terminal
// count; the request is cleared by a take pulse (a new terminal count wins over take).
module tx_skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic reset,
  input  logic take,
  output logic pending
);

  localparam int unsigned CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             terminal_c;

  assign terminal_c = (cnt_q == CNT_W'(SKP_INTERVAL - 1));

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    pending_d = pending_q;
    if (take) pending_d = 1'b0;
    if (terminal_c) begin
      cnt_d     = '0;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/tx_lane_stripe_ctrl.sv
// 2-lane TX striper: even bytes to lane 0, odd to lane 1, pads odd-length packets.
// Periodic COM/SKP ordered-set insertion is built only when SKP_INSERT_EN is defined.
module tx_lane_stripe_ctrl
  import phy_tx_pkg::*;
#(
`ifdef SKP_INSERT_EN
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_LEN      = 4,
  parameter logic [7:0]  COM_BYTE     = COM_SYM,
  parameter logic [7:0]  SKP_BYTE     = SKP_SYM,
`endif
  parameter logic [7:0]  PAD_BYTE     = PAD_SYM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic       out_valid,
  output logic       out_k,
  output logic       out_pad
);

  logic [1:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  lane_pair_t out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       out_k_q, out_k_d;
  logic       out_pad_q, out_pad_d;
  logic       accept_c;

`ifdef SKP_INSERT_EN
  localparam int unsigned LEN_W = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;

  logic [LEN_W-1:0] skp_cnt_q, skp_cnt_d;
  logic             skp_pending;
  logic             skp_take_c;

  tx_skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk    (clk),
    .reset  (reset),
    .take   (skp_take_c),
    .pending(skp_pending)
  );

  // Stall the source for the take cycle and while the ordered set drains.
  assign in_ready = (state_q != ST_SKP) && !(state_q == ST_IDLE && skp_pending);
`else
  assign in_ready = 1'b1;
`endif

  assign accept_c = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_k_d     = 1'b0;
    out_pad_d   = 1'b0;
`ifdef SKP_INSERT_EN
    skp_take_c  = 1'b0;
    skp_cnt_d   = skp_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SKP_INSERT_EN
        // COM goes out in the take cycle, so the SKP state covers only the SKP symbols.
        if (skp_pending) begin
          skp_take_c  = 1'b1;
          out_d       = {COM_BYTE, COM_BYTE};
          out_valid_d = 1'b1;
          out_k_d     = 1'b1;
          skp_cnt_d   = LEN_W'(1);
          state_d     = ST_SKP;
        end else
`endif
        if (accept_c) begin
          if (in_last) begin
            out_d[0]    = in_data;
            out_d[1]    = PAD_BYTE;
            out_valid_d = 1'b1;
            out_pad_d   = 1'b1;
          end else begin
            hold_d  = in_data;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (accept_c) begin
          out_d[0]    = hold_q;
          out_d[1]    = in_data;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`ifdef SKP_INSERT_EN
      ST_SKP: begin
        out_d       = {SKP_BYTE, SKP_BYTE};
        out_valid_d = 1'b1;
        out_k_d     = 1'b1;
        if (skp_cnt_q == LEN_W'(SKP_LEN - 1)) begin
          skp_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          skp_cnt_d = skp_cnt_q + LEN_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_k_q     <= 1'b0;
      out_pad_q   <= 1'b0;
`ifdef SKP_INSERT_EN
      skp_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_k_q     <= out_k_d;
      out_pad_q   <= out_pad_d;
`ifdef SKP_INSERT_EN
      skp_cnt_q   <= skp_cnt_d;
`endif
    end
  end

  assign out0      = out_q[0];
  assign out1      = out_q[1];
  assign out_valid = out_valid_q;
  assign out_k     = out_k_q;
  assign out_pad   = out_pad_q;

endmodule
